// File: rtl/symbol_histogram.sv
// Symbol-frequency collector: counts legal symbols, buffers the sequence, exposes random read.
// Latency: Fin/Len/counts update on the accepting edge; Rd_data is 1 cycle behind Rd_addr.
// Backpressure: In_ready high only while collecting; drops to 0 once full or terminated.
module symbol_histogram #(
  parameter int SYM_W   = 4,
  parameter int NUM_SYM = 10,
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 9
) (
  input  logic                     Clk_in,
  input  logic                     nRst,
  input  logic                     Start,
  input  logic                     In_valid,
  input  logic [SYM_W-1:0]         Data_in,
  output logic                     In_ready,
  output logic [NUM_SYM*CNT_W-1:0] Cnt_all,
  output logic [LEN_W:0]           Len,
  output logic                     Busy,
  output logic                     Fin,
  output logic                     Term,
  input  logic [LEN_W-1:0]         Rd_addr,
  output logic [SYM_W-1:0]         Rd_data
);

  localparam int MAX_LEN = 1 << LEN_W;
  localparam logic [SYM_W:0] NUM_LIM  = (SYM_W+1)'(NUM_SYM);
  localparam logic [LEN_W:0] LAST_LEN = (LEN_W+1)'(MAX_LEN - 1);
  localparam logic [LEN_W:0] LEN_ONE  = (LEN_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A counter narrower than LEN_W+1 could wrap on a full buffer of one symbol.
  generate
    if (CNT_W < LEN_W + 1) begin : g_bad_cnt_w
      $error("symbol_histogram: CNT_W must be >= LEN_W+1");
    end
    if (NUM_SYM > (1 << SYM_W)) begin : g_bad_num_sym
      $error("symbol_histogram: NUM_SYM must be <= 2**SYM_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t           state;
  logic [LEN_W:0]   len_q;
  logic [CNT_W-1:0] cnt [NUM_SYM];
  logic [SYM_W-1:0] mem [MAX_LEN];

  logic accept;
  logic legal;
  logic last;

  assign accept = In_valid & In_ready;
  // Symbols at or above NUM_SYM are terminators rather than data.
  assign legal  = ({1'b0, Data_in} < NUM_LIM);
  // This accept fills the final buffer slot.
  assign last   = (len_q == LAST_LEN);
  assign Len    = len_q;

  // Control FSM with registered handshake/status outputs and the length counter.
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      state    <= S_IDLE;
      Busy     <= 1'b0;
      In_ready <= 1'b0;
      Fin      <= 1'b0;
      Term     <= 1'b0;
      len_q    <= '0;
    end else if (Start) begin
      // Start wins over any same-cycle handshake; that symbol is dropped.
      state    <= S_COLLECT;
      Busy     <= 1'b1;
      In_ready <= 1'b1;
      Fin      <= 1'b0;
      Term     <= 1'b0;
      len_q    <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (accept) begin
            if (legal) begin
              len_q <= len_q + LEN_ONE;
              if (last) begin
                state    <= S_DONE;
                Busy     <= 1'b0;
                In_ready <= 1'b0;
                Fin      <= 1'b1;
                Term     <= 1'b0;
              end
            end else begin
              state    <= S_DONE;
              Busy     <= 1'b0;
              In_ready <= 1'b0;
              Fin      <= 1'b1;
              Term     <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE hold everything until Start.
        end
      endcase
    end
  end

  // Per-symbol occurrence counters, cleared by Start.
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      for (int k = 0; k < NUM_SYM; k++) cnt[k] <= '0;
    end else if (Start) begin
      for (int k = 0; k < NUM_SYM; k++) cnt[k] <= '0;
    end else if (accept && legal) begin
      for (int k = 0; k < NUM_SYM; k++) begin
        if (Data_in == SYM_W'(k)) cnt[k] <= cnt[k] + CNT_ONE;
      end
    end
  end

  // Sequence buffer write; contents survive reset and Start.
  always_ff @(posedge Clk_in) begin
    if (accept && legal && !Start) mem[len_q[LEN_W-1:0]] <= Data_in;
  end

  // Registered read port; a same-address write this cycle is not yet visible.
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) Rd_data <= '0;
    else       Rd_data <= mem[Rd_addr];
  end

  generate
    for (genvar gk = 0; gk < NUM_SYM; gk++) begin : g_cnt_flat
      assign Cnt_all[gk*CNT_W +: CNT_W] = cnt[gk];
    end
  endgenerate

endmodule

// File: tb/tb_symbol_histogram.sv
// Bench for symbol_histogram: default instance against a queue/array reference, plus a wide instance.
// Latency: model state is compared 1 time unit after each rising edge.
// Backpressure: model stops accepting once full or terminated, mirroring In_ready expectations.
module tb_symbol_histogram;

  logic       Clk_in = 1'b0;
  logic       nRst = 1'b0;
  logic       Start = 1'b0;
  logic       In_valid = 1'b0;
  logic [3:0] Data_in = '0;
  logic       In_ready;
  logic [89:0] Cnt_all;
  logic [8:0] Len;
  logic       Busy, Fin, Term;
  logic [7:0] Rd_addr = '0;
  logic [3:0] Rd_data;

  logic       w_Start = 1'b0;
  logic       w_valid = 1'b0;
  logic [7:0] w_data = '0;
  logic       w_ready;
  logic [999:0] w_cnt_all;
  logic [4:0] w_len;
  logic       w_busy, w_fin, w_term;
  logic [3:0] w_rd_addr = '0;
  logic [7:0] w_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 Clk_in = ~Clk_in;

  symbol_histogram dut (
    .Clk_in(Clk_in), .nRst(nRst), .Start(Start), .In_valid(In_valid), .Data_in(Data_in),
    .In_ready(In_ready), .Cnt_all(Cnt_all), .Len(Len), .Busy(Busy), .Fin(Fin), .Term(Term),
    .Rd_addr(Rd_addr), .Rd_data(Rd_data)
  );

  symbol_histogram #(.SYM_W(8), .NUM_SYM(200), .LEN_W(4), .CNT_W(5)) dut_w (
    .Clk_in(Clk_in), .nRst(nRst), .Start(w_Start), .In_valid(w_valid), .Data_in(w_data),
    .In_ready(w_ready), .Cnt_all(w_cnt_all), .Len(w_len), .Busy(w_busy), .Fin(w_fin), .Term(w_term),
    .Rd_addr(w_rd_addr), .Rd_data(w_rd_data)
  );

  // Reference: histogram array, stored-sequence array, collecting/finished flags.
  int m_cnt [10];
  int m_len;
  bit m_col, m_fin, m_term;
  int m_mem [256];
  bit m_known [256];
  int m_rd;
  bit m_rd_known;

  task automatic model_clear();
    for (int k = 0; k < 10; k++) m_cnt[k] = 0;
    m_len = 0; m_fin = 0; m_term = 0;
  endtask

  // One clock of the default instance: drive, advance the reference, land 1 unit after the edge.
  task automatic step(input bit s, input bit v, input int d);
    Start = s; In_valid = v; Data_in = 4'(d);
    @(posedge Clk_in);
    m_rd = m_mem[Rd_addr]; m_rd_known = m_known[Rd_addr];
    if (s) begin
      model_clear(); m_col = 1;
    end else if (m_col && v) begin
      if (d < 10) begin
        m_cnt[d]++; m_mem[m_len] = d; m_known[m_len] = 1; m_len++;
        if (m_len == 256) begin m_col = 0; m_fin = 1; end
      end else begin
        m_col = 0; m_fin = 1; m_term = 1;
      end
    end
    #1;
  endtask

  task automatic wstep(input bit s, input bit v, input int d);
    w_Start = s; w_valid = v; w_data = 8'(d);
    @(posedge Clk_in); #1;
  endtask

  task automatic test_reset();
    nRst = 0; #3;
    checks++; if (Cnt_all !== '0 || Len !== '0) begin errors++; $display("FAIL reset_cnt_len cnt=%h len=%0d want 0", Cnt_all, Len); end
    checks++; if ({Busy, Fin, Term, In_ready} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {Busy, Fin, Term, In_ready}); end
    checks++; if (Rd_data !== '0) begin errors++; $display("FAIL reset_rd got %0d want 0", Rd_data); end
    checks++; if (w_cnt_all !== '0 || w_len !== '0 || {w_busy, w_fin, w_term, w_ready} !== 4'b0) begin errors++; $display("FAIL reset_wide len=%0d flags=%b want 0", w_len, {w_busy, w_fin, w_term, w_ready}); end
    @(posedge Clk_in); #1; nRst = 1;
    model_clear(); m_col = 0;
    for (int i = 0; i < 256; i++) m_known[i] = 0;
    step(0, 1, 3);
    checks++; if (Len !== '0 || In_ready !== 1'b0) begin errors++; $display("FAIL idle_ignores len=%0d rdy=%b want 0 0", Len, In_ready); end
  endtask

  task automatic test_basic();
    int syms [5] = '{3, 3, 7, 0, 15};
    step(1, 0, 0);
    checks++; if (Busy !== 1'b1 || In_ready !== 1'b1 || Fin !== 1'b0) begin errors++; $display("FAIL basic_start busy=%b rdy=%b fin=%b want 1 1 0", Busy, In_ready, Fin); end
    foreach (syms[i]) step(0, 1, syms[i]);
    for (int k = 0; k < 10; k++) begin
      checks++; if (Cnt_all[k*9 +: 9] !== 9'(m_cnt[k])) begin errors++; $display("FAIL basic_cnt%0d got %0d want %0d", k, Cnt_all[k*9 +: 9], m_cnt[k]); end
    end
    checks++; if (Cnt_all[27 +: 9] !== 9'd2 || Cnt_all[63 +: 9] !== 9'd1) begin errors++; $display("FAIL basic_cnt37 got %0d %0d want 2 1", Cnt_all[27 +: 9], Cnt_all[63 +: 9]); end
    checks++; if (Len !== 9'd4 || Fin !== 1'b1 || Term !== 1'b1 || Busy !== 1'b0 || In_ready !== 1'b0) begin errors++; $display("FAIL basic_status len=%0d fin=%b term=%b busy=%b rdy=%b want 4 1 1 0 0", Len, Fin, Term, Busy, In_ready); end
    for (int i = 0; i < 4; i++) begin
      Rd_addr = 8'(i); step(0, 0, 0);
      checks++; if (Rd_data !== 4'(syms[i])) begin errors++; $display("FAIL basic_rd%0d got %0d want %0d", i, Rd_data, syms[i]); end
    end
  endtask

  task automatic test_collision();
    step(1, 0, 0);
    Rd_addr = 8'd0; step(0, 1, 8);
    checks++; if (!m_rd_known || Rd_data !== 4'(m_rd) || Rd_data !== 4'd3) begin errors++; $display("FAIL coll_old got %0d want 3", Rd_data); end
    step(0, 0, 0);
    checks++; if (Rd_data !== 4'd8) begin errors++; $display("FAIL coll_new got %0d want 8", Rd_data); end
  endtask

  task automatic test_fill();
    step(1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 5);
      if (i == 254) begin
        checks++; if (Fin !== 1'b0 || Busy !== 1'b1 || Len !== 9'd255) begin errors++; $display("FAIL fill_255 fin=%b busy=%b len=%0d want 0 1 255", Fin, Busy, Len); end
      end
    end
    checks++; if (Len !== 9'd256 || Fin !== 1'b1 || Term !== 1'b0 || In_ready !== 1'b0) begin errors++; $display("FAIL fill_done len=%0d fin=%b term=%b rdy=%b want 256 1 0 0", Len, Fin, Term, In_ready); end
    step(0, 1, 5);
    checks++; if (Len !== 9'd256 || Cnt_all[45 +: 9] !== 9'd256 || Cnt_all[45 +: 9] !== 9'(m_cnt[5])) begin errors++; $display("FAIL fill_257 len=%0d cnt5=%0d want 256 256", Len, Cnt_all[45 +: 9]); end
  endtask

  task automatic test_gaps();
    bit vs [4] = '{1, 0, 0, 1};
    int ds [4] = '{1, 7, 7, 2};
    step(1, 0, 0);
    foreach (vs[i]) begin
      step(0, vs[i], ds[i]);
      checks++; if (Busy !== 1'b1 || Len !== 9'(m_len)) begin errors++; $display("FAIL gaps_busy%0d busy=%b len=%0d want 1 %0d", i, Busy, Len, m_len); end
    end
    checks++; if (Cnt_all[9 +: 9] !== 9'd1 || Cnt_all[18 +: 9] !== 9'd1 || Cnt_all[63 +: 9] !== 9'd0 || Len !== 9'd2) begin errors++; $display("FAIL gaps_cnt c1=%0d c2=%0d c7=%0d len=%0d want 1 1 0 2", Cnt_all[9 +: 9], Cnt_all[18 +: 9], Cnt_all[63 +: 9], Len); end
  endtask

  task automatic test_restart();
    step(1, 0, 0); step(0, 1, 1); step(0, 1, 1);
    step(1, 1, 4); step(0, 1, 9); step(0, 1, 10);
    for (int k = 0; k < 10; k++) begin
      checks++; if (Cnt_all[k*9 +: 9] !== 9'(m_cnt[k])) begin errors++; $display("FAIL restart_cnt%0d got %0d want %0d", k, Cnt_all[k*9 +: 9], m_cnt[k]); end
    end
    checks++; if (Cnt_all[81 +: 9] !== 9'd1 || Len !== 9'd1 || Term !== 1'b1 || Fin !== 1'b1) begin errors++; $display("FAIL restart_status c9=%0d len=%0d term=%b fin=%b want 1 1 1 1", Cnt_all[81 +: 9], Len, Term, Fin); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, int'($urandom_range(0, 9)));
    checks++; if (Len !== 9'd10) begin errors++; $display("FAIL rmid_pre len=%0d want 10", Len); end
    #2 nRst = 0; #1;
    checks++; if (Cnt_all !== '0 || Len !== '0 || {Busy, Fin, Term, In_ready} !== 4'b0 || Rd_data !== '0) begin errors++; $display("FAIL rmid_async len=%0d flags=%b rd=%0d want all 0", Len, {Busy, Fin, Term, In_ready}, Rd_data); end
    nRst = 1;
    model_clear(); m_col = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 3);
    checks++; if (Len !== '0 || In_ready !== 1'b0 || Cnt_all !== '0) begin errors++; $display("FAIL rmid_ignore len=%0d rdy=%b want 0 0", Len, In_ready); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int cyc = 0;
      int sum;
      step(1, 0, 0);
      while (m_col && cyc < 800) begin
        bit v = ($urandom_range(0, 3) != 0);
        int d = (r < 5 && $urandom_range(0, 24) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        bit s = (r == 3 && cyc == 20);
        step(s, v, d);
        cyc++;
        checks++; if (Len !== 9'(m_len) || Busy !== m_col || Fin !== m_fin) begin errors++; $display("FAIL rand%0d_cyc%0d len=%0d busy=%b fin=%b want %0d %b %b", r, cyc, Len, Busy, Fin, m_len, m_col, m_fin); end
      end
      checks++; if (m_col) begin errors++; $display("FAIL rand%0d_budget still collecting after %0d cycles want done", r, cyc); end
      sum = 0;
      for (int k = 0; k < 10; k++) begin
        sum += int'(Cnt_all[k*9 +: 9]);
        checks++; if (Cnt_all[k*9 +: 9] !== 9'(m_cnt[k])) begin errors++; $display("FAIL rand%0d_cnt%0d got %0d want %0d", r, k, Cnt_all[k*9 +: 9], m_cnt[k]); end
      end
      checks++; if (Term !== m_term || sum != m_len) begin errors++; $display("FAIL rand%0d_term term=%b sum=%0d want %b %0d", r, Term, sum, m_term, m_len); end
      for (int i = 0; i < m_len; i++) begin
        Rd_addr = 8'(i); step(0, 0, 0);
        checks++; if (!m_rd_known || Rd_data !== 4'(m_rd)) begin errors++; $display("FAIL rand%0d_rd%0d got %0d want %0d", r, i, Rd_data, m_rd); end
      end
    end
  endtask

  task automatic test_wide();
    int syms [3] = '{199, 0, 199};
    wstep(1, 0, 0);
    foreach (syms[i]) wstep(0, 1, syms[i]);
    wstep(0, 1, 200);
    checks++; if (w_cnt_all[995 +: 5] !== 5'd2 || w_cnt_all[0 +: 5] !== 5'd1) begin errors++; $display("FAIL wide_cnt c199=%0d c0=%0d want 2 1", w_cnt_all[995 +: 5], w_cnt_all[0 +: 5]); end
    checks++; if (w_len !== 5'd3 || w_term !== 1'b1 || w_fin !== 1'b1 || w_ready !== 1'b0) begin errors++; $display("FAIL wide_status len=%0d term=%b fin=%b rdy=%b want 3 1 1 0", w_len, w_term, w_fin, w_ready); end
    for (int i = 0; i < 3; i++) begin
      w_rd_addr = 4'(i); wstep(0, 0, 0);
      checks++; if (w_rd_data !== 8'(syms[i])) begin errors++; $display("FAIL wide_rd%0d got %0d want %0d", i, w_rd_data, syms[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_fill();
    test_gaps();
    test_restart();
    test_reset_mid();
    test_random();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete within bound");
    $fatal(1);
  end

endmodule
